// File: rtl/regfile_pkg.sv
// Shared sizing and types for the 32 x 32 register file and its write decoder.
package regfile_pkg;

  localparam int WIDTH    = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 1 << ADDR_W;
  localparam int ZERO_REG = 0;

  typedef logic [WIDTH-1:0]  reg_word_t;
  typedef logic [ADDR_W-1:0] reg_addr_t;

endpackage

// File: rtl/regfile_decoder.sv
// One-hot write-enable decoder with enable; line 0 is not produced because
// register 0 has no storage to enable.
module regfile_decoder
  import regfile_pkg::*;
#(
  parameter int ADDR_W = regfile_pkg::ADDR_W
) (
  input  logic                       enable,
  input  logic [ADDR_W-1:0]          addr,
  output logic [(1 << ADDR_W)-1:1]   lines
);

  localparam int LINE_COUNT = 1 << ADDR_W;

  always_comb begin
    lines = '0;
    for (int k = 1; k < LINE_COUNT; k++) begin
      lines[k] = enable && (addr == ADDR_W'(k));
    end
  end

endmodule

// File: rtl/regfile32.sv
// Two-read, one-write register file with register 0 tied to zero and optional
// same-cycle forwarding of the write data onto the read ports.
module regfile32
  import regfile_pkg::*;
#(
  parameter int WIDTH  = regfile_pkg::WIDTH,
  parameter int ADDR_W = regfile_pkg::ADDR_W,
  parameter bit BYPASS = 1'b0
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic [ADDR_W-1:0] ReadRegister1,
  input  logic [ADDR_W-1:0] ReadRegister2,
  output logic [WIDTH-1:0]  ReadData1,
  output logic [WIDTH-1:0]  ReadData2,
  input  logic [ADDR_W-1:0] WriteRegister,
  input  logic [WIDTH-1:0]  WriteData,
  input  logic              RegWrite
);

  localparam int REG_COUNT = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

  logic [REG_COUNT-1:1] write_en;
  logic [WIDTH-1:0]     regs [1:REG_COUNT-1];
  logic                 fwd1;
  logic                 fwd2;

  regfile_decoder #(
    .ADDR_W (ADDR_W)
  ) u_decoder (
    .enable (RegWrite),
    .addr   (WriteRegister),
    .lines  (write_en)
  );

  // The asynchronous clear has priority, so an edge that lands while reset is
  // low never writes.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int k = 1; k < REG_COUNT; k++) begin
        regs[k] <= '0;
      end
    end else begin
      for (int k = 1; k < REG_COUNT; k++) begin
        if (write_en[k]) begin
          regs[k] <= WriteData;
        end
      end
    end
  end

  assign fwd1 = BYPASS && Reset_n && RegWrite &&
                (WriteRegister == ReadRegister1) && (ReadRegister1 != ZERO_ADDR);
  assign fwd2 = BYPASS && Reset_n && RegWrite &&
                (WriteRegister == ReadRegister2) && (ReadRegister2 != ZERO_ADDR);

  // Address 0 matches no stored register, so it falls through to the zero default.
  always_comb begin
    ReadData1 = '0;
    ReadData2 = '0;
    for (int k = 1; k < REG_COUNT; k++) begin
      if (ReadRegister1 == ADDR_W'(k)) ReadData1 = regs[k];
      if (ReadRegister2 == ADDR_W'(k)) ReadData2 = regs[k];
    end
    if (fwd1) ReadData1 = WriteData;
    if (fwd2) ReadData2 = WriteData;
  end

endmodule

// File: tb/tb_regfile32.sv
// Bench for regfile32: one instance without and one with write forwarding,
// both checked against an array model of the register contents.
module tb_regfile32;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic [4:0]  ra1, ra2, wa;
  logic [31:0] wd;
  logic        we;
  logic [31:0] rd1, rd2, rd1_bp, rd2_bp;

  logic [31:0] model [32];
  logic [31:0] exp_q [$];
  int          checks = 0;
  int          errors = 0;

  always #5 Clk = ~Clk;

  regfile32 #(.WIDTH(32), .ADDR_W(5), .BYPASS(1'b0)) dut (
    .Clk(Clk), .Reset_n(Reset_n),
    .ReadRegister1(ra1), .ReadRegister2(ra2),
    .ReadData1(rd1), .ReadData2(rd2),
    .WriteRegister(wa), .WriteData(wd), .RegWrite(we)
  );

  regfile32 #(.WIDTH(32), .ADDR_W(5), .BYPASS(1'b1)) dut_bp (
    .Clk(Clk), .Reset_n(Reset_n),
    .ReadRegister1(ra1), .ReadRegister2(ra2),
    .ReadData1(rd1_bp), .ReadData2(rd2_bp),
    .WriteRegister(wa), .WriteData(wd), .RegWrite(we)
  );

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic [31:0] e1;
    logic [31:0] e2;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, expv, $time);
    end
  endtask

  // Reference read: reset forces zero, address 0 is zero, forwarding only on the bypass copy.
  function automatic logic [31:0] ref_read(input logic [4:0] a, input bit bp);
    if (!Reset_n || a == 5'd0) return 32'd0;
    if (bp && we && wa == a) return wd;
    return model[a];
  endfunction

  task automatic check_ports(input string name);
    exp_q.push_back(ref_read(ra1, 1'b0));
    exp_q.push_back(ref_read(ra2, 1'b0));
    exp_q.push_back(ref_read(ra1, 1'b1));
    exp_q.push_back(ref_read(ra2, 1'b1));
    check({name, ".rd1"},    rd1,    exp_q.pop_front());
    check({name, ".rd2"},    rd2,    exp_q.pop_front());
    check({name, ".rd1_bp"}, rd1_bp, exp_q.pop_front());
    check({name, ".rd2_bp"}, rd2_bp, exp_q.pop_front());
  endtask

  // Inputs change just after the falling edge; the model commits what the
  // rising edge should have written, then control returns after the next fall.
  task automatic tick();
    @(posedge Clk);
    if (Reset_n && we && wa != 5'd0) model[wa] = wd;
    @(negedge Clk);
    #1;
  endtask

  task automatic drive(input logic w, input logic [4:0] a, input logic [31:0] d,
                       input logic [4:0] r1, input logic [4:0] r2);
    we = w; wa = a; wd = d; ra1 = r1; ra2 = r2;
    #1;
  endtask

  task automatic clear_model();
    for (int i = 0; i < 32; i++) model[i] = 32'd0;
  endtask

  initial begin
    Reset_n = 1'b0;
    clear_model();
    drive(1'b0, 5'd0, 32'd0, 5'd0, 5'd0);

    // Reset: reads are zero at several addresses, and a write during reset is dropped.
    foreach (vecs[i]) vecs[i] = '{1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 32'd0, 32'd0};
    drive(1'b0, 5'd0, 32'd0, 5'd0, 5'd0);   check_ports("rst_a0");
    drive(1'b0, 5'd0, 32'd0, 5'd5, 5'd5);   check_ports("rst_a5");
    drive(1'b0, 5'd0, 32'd0, 5'd31, 5'd31); check_ports("rst_a31");
    drive(1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd5);
    tick();
    check("rst_write_blocked", rd1_bp, 32'd0);
    @(negedge Clk);
    Reset_n = 1'b1;
    drive(1'b0, 5'd0, 32'd0, 5'd5, 5'd5);
    #1;
    check("post_release_r5", rd1, 32'd0);
    check("post_release_r5_p2", rd2, 32'd0);

    // Table of single-edge writes followed by reads with the write enable dropped.
    vecs[0] = '{1'b1, 5'd2,  32'd42,         5'd2,  5'd2,  32'd42,         32'd42};
    vecs[1] = '{1'b1, 5'd2,  32'd15,         5'd2,  5'd2,  32'd15,         32'd15};
    vecs[2] = '{1'b0, 5'd2,  32'd16,         5'd2,  5'd2,  32'd15,         32'd15};
    vecs[3] = '{1'b1, 5'd0,  32'h12345678,   5'd0,  5'd0,  32'd0,          32'd0};
    vecs[4] = '{1'b1, 5'd17, 32'd17,         5'd17, 5'd2,  32'd17,         32'd15};
    vecs[5] = '{1'b1, 5'd9,  32'd9,          5'd9,  5'd9,  32'd9,          32'd9};
    vecs[6] = '{1'b1, 5'd3,  32'hFFFFFFFF,   5'd2,  5'd4,  32'd15,         32'd0};
    vecs[7] = '{1'b0, 5'd0,  32'd0,          5'd3,  5'd17, 32'hFFFFFFFF,   32'd17};
    vecs[8] = '{1'b1, 5'd31, 32'hA5A5_0001,  5'd31, 5'd30, 32'hA5A5_0001,  32'd0};
    vecs[9] = '{1'b1, 5'd31, 32'h0000_0002,  5'd31, 5'd9,  32'h0000_0002,  32'd9};
    for (int i = 0; i < 10; i++) begin
      drive(vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].ra1, vecs[i].ra2);
      tick();
      we = 1'b0;
      #1;
      check($sformatf("vec%0d.rd1", i), rd1, vecs[i].e1);
      check($sformatf("vec%0d.rd2", i), rd2, vecs[i].e2);
      check($sformatf("vec%0d.rd1_bp", i), rd1_bp, vecs[i].e1);
      check($sformatf("vec%0d.rd2_bp", i), rd2_bp, vecs[i].e2);
    end

    // Decoder isolation: every register holds its own value.
    for (int k = 1; k < 32; k++) begin
      drive(1'b1, 5'(k), 32'(k + 100), 5'd0, 5'd0);
      tick();
    end
    we = 1'b0;
    for (int k = 0; k < 32; k++) begin
      drive(1'b0, 5'd0, 32'd0, 5'(k), 5'(31 - k));
      check($sformatf("iso_p1_r%0d", k), rd1, (k == 0) ? 32'd0 : 32'(k + 100));
      check($sformatf("iso_p2_r%0d", 31 - k), rd2, (k == 31) ? 32'd0 : 32'(131 - k));
    end
    drive(1'b1, 5'd3, 32'hFFFFFFFF, 5'd2, 5'd4);
    tick();
    we = 1'b0;
    #1;
    check("iso_r2_kept", rd1, 32'd102);
    check("iso_r4_kept", rd2, 32'd104);

    // Forwarding versus pre-edge value on a same-cycle write and read of r4.
    drive(1'b1, 5'd4, 32'd77, 5'd4, 5'd4);
    check("nobp_pre_edge", rd1, 32'd104);
    check("bp_pre_edge", rd1_bp, 32'd77);
    check("bp_pre_edge_p2", rd2_bp, 32'd77);
    tick();
    we = 1'b0;
    #1;
    check("nobp_post_edge", rd2, 32'd77);

    // Back-to-back writes to one register: the last one wins.
    drive(1'b1, 5'd6, 32'h1111, 5'd6, 5'd0);
    tick();
    drive(1'b1, 5'd6, 32'h2222, 5'd6, 5'd0);
    tick();
    we = 1'b0;
    #1;
    check("b2b_last_wins", rd1, 32'h2222);

    // Asynchronous reset mid-operation clears storage without a clock edge.
    #1;
    Reset_n = 1'b0;
    clear_model();
    #1;
    check("async_clear_r6", rd1, 32'd0);
    drive(1'b1, 5'd6, 32'h3333, 5'd6, 5'd6);
    tick();
    Reset_n = 1'b1;
    we = 1'b0;
    #1;
    check("no_write_in_reset", rd1, 32'd0);

    // Randomized traffic with occasional reset pulses against the model.
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 39) == 0) begin
        Reset_n = 1'b0;
        clear_model();
      end
      drive(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
            5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
      if ($urandom_range(0, 3) == 0) ra2 = wa;
      if ($urandom_range(0, 3) == 0) ra1 = wa;
      #1;
      check_ports($sformatf("rand%0d", n));
      tick();
      Reset_n = 1'b1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
